// File: rtl/key_entry_pkg.sv
// Shared types and constants for the key entry sequencer: FSM states,
// key-mask bit positions and the legal range of the DIGITS parameter.
package key_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Bits 22..23 of the decoder mask carry no meaning here and are never tracked.
  localparam int NUM_KEYS = 22;

  localparam logic [4:0] KEY_L0    = 5'd0;
  localparam logic [4:0] KEY_R0    = 5'd10;
  localparam logic [4:0] KEY_ENTER = 5'd20;
  localparam logic [4:0] KEY_SPACE = 5'd21;

  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 6;

endpackage

// File: rtl/key_press_encoder.sv
// Turns the decoder's key mask into a single press event per key_valid:
// rising edges only, lowest index wins, plus an all-keys-released flag.
module key_press_encoder
  import key_entry_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic [NUM_KEYS-1:0] key_down,
  output logic                press_valid,
  output logic [4:0]          press_idx,
  output logic                all_released
);

  logic [NUM_KEYS-1:0] key_prev_q;
  logic [NUM_KEYS-1:0] key_prev_d;
  logic [NUM_KEYS-1:0] press;

  always_comb begin
    key_prev_d = key_valid ? key_down : key_prev_q;
    press      = key_down & ~key_prev_q;
    press_idx  = '0;
    // Scan downwards so the last hit is the lowest set bit.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press[i]) press_idx = 5'(i);
    end
  end

  assign press_valid  = key_valid & (|press);
  assign all_released = (key_prev_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_prev_q <= '0;
    else        key_prev_q <= key_prev_d;
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// Two-player BCD entry sequencer: top-row digits feed buffer A, keypad digits
// feed buffer B, Enter hands both to game logic, Space clears.
module key_entry_ctrl
  import key_entry_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [23:0]           key_down,
  output logic [4*DIGITS-1:0]   entry_a,
  output logic [4*DIGITS-1:0]   entry_b,
  output logic [2:0]            count_a,
  output logic [2:0]            count_b,
  output logic                  commit_valid,
  output logic [4*DIGITS-1:0]   commit_a,
  output logic [4*DIGITS-1:0]   commit_b,
  input  logic                  commit_ready,
  output logic                  overflow,
  output logic                  locked,
  output logic [1:0]            state_dbg
);

  localparam int         W        = 4 * DIGITS;
  localparam logic [2:0] DIGITS_C = 3'(DIGITS);

  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
    $error("key_entry_ctrl: DIGITS out of range");
  end

  // Handshake: the committed pair transfers in any cycle where commit_valid
  // and commit_ready are both high; commit_a/commit_b hold until then.

  logic         press_valid, all_released;
  logic [4:0]   press_idx;
  logic         unused_keys;

  state_e       state_q, state_d;
  logic [W-1:0] entry_a_q, entry_a_d, entry_b_q, entry_b_d;
  logic [W-1:0] commit_a_q, commit_a_d, commit_b_q, commit_b_d;
  logic [W-1:0] shift_a, shift_b;
  logic [2:0]   count_a_q, count_a_d, count_b_q, count_b_d;
  logic         commit_valid_q, commit_valid_d;
  logic         overflow_q, overflow_d, locked_q, locked_d;
  logic         is_dig_a, is_dig_b, is_enter, is_space;
  logic         room_a, room_b, any_digits, taking_keys;
  logic [3:0]   digit_b;

  assign unused_keys = ^key_down[23:22];

  key_press_encoder u_enc (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_down     (key_down[NUM_KEYS-1:0]),
    .press_valid  (press_valid),
    .press_idx    (press_idx),
    .all_released (all_released)
  );

  assign is_dig_a    = press_valid && (press_idx < KEY_R0);
  assign is_dig_b    = press_valid && (press_idx >= KEY_R0) && (press_idx < KEY_ENTER);
  assign is_enter    = press_valid && (press_idx == KEY_ENTER);
  assign is_space    = press_valid && (press_idx == KEY_SPACE);
  assign room_a      = count_a_q < DIGITS_C;
  assign room_b      = count_b_q < DIGITS_C;
  assign any_digits  = (count_a_q != 3'd0) || (count_b_q != 3'd0);
  assign taking_keys = (state_q == ST_IDLE) || (state_q == ST_ENTRY);
  assign digit_b     = 4'(press_idx - KEY_R0);

  // New digit enters at the least-significant nibble; the oldest falls off the top.
  if (DIGITS > 1) begin : g_shift
    assign shift_a = {entry_a_q[W-5:0], press_idx[3:0]};
    assign shift_b = {entry_b_q[W-5:0], digit_b};
  end else begin : g_single
    assign shift_a = press_idx[3:0];
    assign shift_b = digit_b;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (is_space)                                          state_d = ST_IDLE;
        else if (is_enter && any_digits)                       state_d = ST_COMMIT;
        else if ((is_dig_a && room_a) || (is_dig_b && room_b)) state_d = ST_ENTRY;
      end
      ST_COMMIT:  if (commit_ready) state_d = ST_RELEASE;
      ST_RELEASE: if (all_released) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    entry_a_d      = entry_a_q;
    entry_b_d      = entry_b_q;
    count_a_d      = count_a_q;
    count_b_d      = count_b_q;
    commit_a_d     = commit_a_q;
    commit_b_d     = commit_b_q;
    commit_valid_d = commit_valid_q;
    overflow_d     = 1'b0;
    if (taking_keys) begin
      if (is_dig_a) begin
        if (room_a) begin
          entry_a_d = shift_a;
          count_a_d = count_a_q + 3'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      if (is_dig_b) begin
        if (room_b) begin
          entry_b_d = shift_b;
          count_b_d = count_b_q + 3'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      if (is_enter && any_digits) begin
        commit_a_d     = entry_a_q;
        commit_b_d     = entry_b_q;
        commit_valid_d = 1'b1;
      end
      if (is_space) begin
        entry_a_d = '0;
        entry_b_d = '0;
        count_a_d = '0;
        count_b_d = '0;
      end
    end else if (state_q == ST_COMMIT && commit_ready) begin
      commit_valid_d = 1'b0;
      entry_a_d      = '0;
      entry_b_d      = '0;
      count_a_d      = '0;
      count_b_d      = '0;
    end
    locked_d = (state_d == ST_COMMIT) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      entry_a_q      <= '0;
      entry_b_q      <= '0;
      count_a_q      <= '0;
      count_b_q      <= '0;
      commit_a_q     <= '0;
      commit_b_q     <= '0;
      commit_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      entry_a_q      <= entry_a_d;
      entry_b_q      <= entry_b_d;
      count_a_q      <= count_a_d;
      count_b_q      <= count_b_d;
      commit_a_q     <= commit_a_d;
      commit_b_q     <= commit_b_d;
      commit_valid_q <= commit_valid_d;
      overflow_q     <= overflow_d;
      locked_q       <= locked_d;
    end
  end

  assign entry_a      = entry_a_q;
  assign entry_b      = entry_b_q;
  assign count_a      = count_a_q;
  assign count_b      = count_b_q;
  assign commit_a     = commit_a_q;
  assign commit_b     = commit_b_q;
  assign commit_valid = commit_valid_q;
  assign overflow     = overflow_q;
  assign locked       = locked_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: directed scenarios plus random key traffic
// against a decimal-arithmetic model, with commits checked by a scoreboard.
module tb_key_entry_ctrl;
  import key_entry_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [23:0]   key_down = '0;
  logic          commit_ready = 1'b0;
  logic [W-1:0]  entry_a, entry_b, commit_a, commit_b;
  logic [2:0]    count_a, count_b;
  logic          commit_valid, overflow, locked;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  key_entry_ctrl #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_down     (key_down),
    .entry_a      (entry_a),
    .entry_b      (entry_b),
    .count_a      (count_a),
    .count_b      (count_b),
    .commit_valid (commit_valid),
    .commit_a     (commit_a),
    .commit_b     (commit_b),
    .commit_ready (commit_ready),
    .overflow     (overflow),
    .locked       (locked),
    .state_dbg    (state_dbg)
  );

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  // Reference model: entries kept as plain decimal numbers.
  logic [21:0] m_prev;
  int          m_av, m_bv, m_ca, m_cb;
  state_e      m_state;
  logic        m_ovf;
  int          m_ovf_total = 0;
  int          ovf_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_prev = '0; m_av = 0; m_bv = 0; m_ca = 0; m_cb = 0;
    m_state = ST_IDLE; m_ovf = 1'b0;
  endfunction

  function automatic void model_clear();
    m_av = 0; m_bv = 0; m_ca = 0; m_cb = 0;
  endfunction

  function automatic void model_key(input logic [23:0] mask);
    logic [21:0] press;
    int idx;
    press  = mask[21:0] & ~m_prev;
    m_prev = mask[21:0];
    m_ovf  = 1'b0;
    if ((m_state == ST_IDLE || m_state == ST_ENTRY) && press != '0) begin
      idx = 0;
      while (!press[idx]) idx++;
      if (idx < 10) begin
        if (m_ca < DIGITS) begin m_av = m_av * 10 + idx; m_ca++; m_state = ST_ENTRY; end
        else m_ovf = 1'b1;
      end else if (idx < 20) begin
        if (m_cb < DIGITS) begin m_bv = m_bv * 10 + (idx - 10); m_cb++; m_state = ST_ENTRY; end
        else m_ovf = 1'b1;
      end else if (idx == 20) begin
        if (m_ca != 0 || m_cb != 0) begin
          exp_q.push_back({to_bcd(m_av), to_bcd(m_bv)});
          m_state = ST_COMMIT;
        end
      end else begin
        model_clear();
        m_state = ST_IDLE;
      end
    end
    if (m_ovf) m_ovf_total++;
  endfunction

  task automatic check_live(input string tag);
    check({tag, ".entry_a"}, entry_a, to_bcd(m_av));
    check({tag, ".entry_b"}, entry_b, to_bcd(m_bv));
    check({tag, ".count_a"}, count_a, m_ca);
    check({tag, ".count_b"}, count_b, m_cb);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".state"}, state_dbg, m_state);
    check({tag, ".locked"}, locked, (m_state == ST_COMMIT || m_state == ST_RELEASE));
  endtask

  // One decoder event; called at a negedge, returns two negedges later.
  task automatic send(input logic [23:0] mask);
    key_valid = 1'b1;
    key_down  = mask;
    model_key(mask);
    @(negedge clk);
    key_valid = 1'b0;
    check_live("key");
    check("key.overflow", overflow, m_ovf);
    check("key.commit_valid", commit_valid, (m_state == ST_COMMIT));
    @(negedge clk);
    if (m_state == ST_RELEASE && m_prev == '0) m_state = ST_IDLE;
    check_state("key");
    check("key.overflow_width", overflow, 1'b0);
  endtask

  task automatic tap(input int idx);
    logic [23:0] m;
    m = '0;
    m[idx] = 1'b1;
    send(m);
    send('0);
  endtask

  // Consumer holds ready low for `hold` cycles, then accepts for one cycle.
  task automatic accept(input int hold);
    check("acc.commit_valid_before", commit_valid, (m_state == ST_COMMIT));
    repeat (hold) @(negedge clk);
    commit_ready = 1'b1;
    if (m_state == ST_COMMIT) begin
      model_clear();
      m_state = ST_RELEASE;
    end
    @(negedge clk);
    commit_ready = 1'b0;
    check("acc.commit_valid_after", commit_valid, 1'b0);
    check_live("acc");
    check_state("acc");
    @(negedge clk);
    if (m_state == ST_RELEASE && m_prev == '0) m_state = ST_IDLE;
    check_state("acc2");
  endtask

  // Scoreboard monitor: the presented pair must match the oldest expected commit.
  always @(negedge clk) begin
    #1;
    if (rst_n && commit_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL commit_unexpected: got %0h required no commit", {commit_a, commit_b});
      end else begin
        check("commit_pair", {commit_a, commit_b}, exp_q[0]);
        if (commit_ready) void'(exp_q.pop_front());
      end
    end
    if (rst_n && overflow) ovf_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  logic [23:0] held;
  int          r;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.entry_a", entry_a, 0);
    check("rst.entry_b", entry_b, 0);
    check("rst.counts", {count_a, count_b}, 0);
    check("rst.commit", {commit_valid, commit_a, commit_b}, 0);
    check("rst.overflow", overflow, 0);
    check("rst.locked", locked, 0);
    check("rst.state", state_dbg, ST_IDLE);
    rst_n = 1'b1;

    tap(1); tap(2); tap(3); tap(17);
    check("digits.entry_a", entry_a, 16'h0123);
    check("digits.count_a", count_a, 3);
    check("digits.entry_b", entry_b, 16'h0007);
    check("digits.count_b", count_b, 1);
    tap(21);

    for (int i = 0; i < 5; i++) tap(9);
    check("ovf.entry_a", entry_a, 16'h9999);
    check("ovf.pulses", ovf_seen, 1);

    send(24'h10_0000);
    accept(10);
    check("enter.state_release", state_dbg, ST_RELEASE);
    send(24'h10_0010);
    check("lock.entry_a", entry_a, 16'h0000);
    send('0);
    check("lock.state_idle", state_dbg, ST_IDLE);
    tap(4);
    check("lock.entry_a_new", entry_a, 16'h0004);

    tap(5);
    tap(21);
    check("space.buffers", {entry_a, entry_b}, 0);
    check("space.state", state_dbg, ST_IDLE);
    tap(20);
    check("empty_enter.commit_valid", commit_valid, 0);

    send(24'h20_0008);
    check("space_digit.entry_a", entry_a, 16'h0003);
    send('0);
    tap(21);

    held = '0;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (m_state == ST_COMMIT && r < 40) begin
        accept($urandom_range(0, 3));
      end else begin
        if (r < 45)      held[$urandom_range(0, 19)] = 1'b1;
        else if (r < 60) held[$urandom_range(0, 23)] = 1'b0;
        else if (r < 66) held[20] = 1'b1;
        else if (r < 69) held[21] = 1'b1;
        else if (r < 80) held = '0;
        else if (r < 88) begin
          held[$urandom_range(0, 21)] = 1'b1;
          held[$urandom_range(0, 21)] = 1'b1;
        end
        else if (r < 92) held[$urandom_range(22, 23)] = 1'b1;
        else             held[20] = 1'b0;
        send(held);
      end
    end
    if (m_state == ST_COMMIT) accept(0);
    send('0);

    tap(21);
    tap(6);
    send(24'h10_0000);
    check("rstc.commit_valid", commit_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstc.entry", {entry_a, entry_b, count_a, count_b}, 0);
    check("rstc.commit", {commit_valid, commit_a, commit_b}, 0);
    check("rstc.flags", {overflow, locked}, 0);
    check("rstc.state", state_dbg, ST_IDLE);
    exp_q.delete();
    model_reset();
    key_down = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tap(2);
    check("rstc.after_entry_a", entry_a, 16'h0002);

    @(negedge clk);
    #2;
    check("end.overflow_count", ovf_seen, m_ovf_total);
    check("end.queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_entry_ctrl.md
# key_entry_ctrl

Sequencer that sits downstream of the PS/2 keyboard decoder and turns its 24-bit `key_down` mask into two committed decimal entries. Player A types on the top-row digits and player B on the numeric keypad; Enter commits both, Space clears. Committed values are handed to game logic over a valid/ready handshake, and new input is locked out until every key is released.

## Interface
- `DIGITS`, default 4: BCD digits per entry buffer, from 1 to 6.
- `clk`  in  1  system clock, same domain as the keyboard decoder.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `key_valid`  in  1  one-cycle pulse from the decoder; `key_down` has just changed.
- `key_down`  in  24  decoder key mask.
  - Bits 0–9: top-row digits 0–9.
  - Bits 10–19: keypad digits 0–9.
  - Bit 20: Enter. Bit 21: Space. Bits 22–23: ignored.
- `entry_a`  out  4*DIGITS  live BCD buffer A, least-significant digit in [3:0].
- `entry_b`  out  4*DIGITS  live BCD buffer B.
- `count_a`, `count_b`  out  3  digits currently held, 0..DIGITS.
- `commit_valid`  out  1  committed pair is presented.
- `commit_a`, `commit_b`  out  4*DIGITS  committed BCD values, stable while `commit_valid`=1.
- `commit_ready`  in  1  consumer accepts the committed pair.
- `overflow`  out  1  one-cycle pulse: a digit was dropped because its buffer was full.
- `locked`  out  1  high in the COMMIT and RELEASE states.

## Operation
- **Reset values.** All outputs are 0. The `key_prev` register is 0. The state is IDLE.
- **Edge extraction.** On each `key_valid`:
  - `press = key_down[21:0] & ~key_prev`.
  - `key_prev <= key_down[21:0]`. This update happens in every state.
  - If more than one bit of `press` is set, only the lowest-index bit is acted on.
  - Key releases produce no action.
- **FSM states:** IDLE, ENTRY, COMMIT, RELEASE.
- **IDLE and ENTRY.** Both states act on a press as follows:
  - Top-row digit d: if `count_a`<DIGITS, `entry_a <= {entry_a[4*DIGITS-5:0], d}` and `count_a++`. Otherwise pulse `overflow`.
  - Keypad digit d: the same operation on buffer B.
  - Space: clear both buffers and both counts. Go to IDLE.
  - Enter with both counts 0: no action.
  - Enter with either count nonzero: copy the buffers to `commit_a`/`commit_b`, set `commit_valid`, go to COMMIT.
  - Any digit accepted in IDLE moves the FSM to ENTRY.
- **COMMIT.**
  - All presses are ignored.
  - `commit_valid` stays high and `commit_a`/`commit_b` are frozen until a cycle with `commit_ready`=1.
  - In that cycle: drop `commit_valid`, clear both buffers and counts, go to RELEASE.
- **RELEASE.**
  - Presses are ignored.
  - Once `key_prev`==0, go to IDLE on the next cycle. This includes the case where `key_prev` is already 0 on entry.
- **Simultaneous events.**
  - `key_valid` in the same cycle as `commit_ready` in COMMIT: the handshake completes and `key_prev` updates; the press is discarded.
  - Space and a digit pressed in the same event: the digit wins, because it has the lower index. Space is lost.
- **Mid-operation reset.** Deasserting `rst_n` clears everything immediately, including a pending commit. After release of reset, keys that are still held look like new presses. This is accepted behaviour.

## Timing
- `key_valid` sampled in cycle N: buffers, counts and `overflow` update in N+1.
- Enter `key_valid` in cycle N: `commit_valid`=1 from N+1.
- `commit_ready` sampled high in cycle M: `commit_valid`=0 and buffers cleared in M+1.
- Minimum handshake: `commit_valid` is high for 1 cycle when `commit_ready` is tied high.
- `overflow` is exactly one cycle wide.
- `locked` is a registered output derived from the state.

## Structure
- Package `key_entry_pkg` holds:
  - The state enum.
  - Bit-index constants: KEY_L0=0, KEY_R0=10, KEY_ENTER=20, KEY_SPACE=21.
  - The DIGITS bounds.
- Sub-module `key_press_encoder`. It registers `key_prev` and outputs `press_valid`, `press_idx[4:0]` and `all_released`.
- Top level holds the FSM, the two shift buffers and the commit registers.

## Test plan
- **Digit entry.** Press and release top-row 1, 2, 3, then keypad 7 (each press and release its own `key_valid`) → `entry_a`=16'h0123, `count_a`=3, `entry_b`=16'h0007, `count_b`=1.
- **Overflow.** Five top-row presses of 9 with DIGITS=4 → `entry_a`=16'h9999. `overflow` pulses once, on the fifth press.
- **Enter with held ready.** Enter with `commit_ready` held 0 for 10 cycles → `commit_valid` stays high and `commit_a` is stable. Raising `commit_ready` → buffers are cleared the next cycle and the state is RELEASE.
- **Release lockout.** In RELEASE, press top-row 4 while Enter is still held → ignored. Release all keys → IDLE. A new top-row 4 → `entry_a`=16'h0004.
- **Space and Enter edge cases.** Space after two digits → both buffers 0, state IDLE. Enter with empty buffers → `commit_valid` stays 0.
- **Reset in COMMIT.** Assert `rst_n`=0 while in COMMIT → all outputs 0 asynchronously. After release of reset the state is IDLE.
